// File: rtl/series_ctrl_pkg.sv
// Shared types for the series-evaluation controller.
// Holds the FSM state encoding and the 13-bit register-control vector,
// together with the control value driven in each state.
package series_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_MULX = 3'd2,
        ST_MULC = 3'd3,
        ST_ACC  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Field order fixes the bit layout of the packed vector (zx is bit 12, s is bit 0).
    typedef struct packed {
        logic zx;
        logic initx;
        logic ldx;
        logic zt;
        logic initt;
        logic ldt;
        logic zr;
        logic initr;
        logic ldr;
        logic zc;
        logic ldc;
        logic enc;
        logic s;
    } ctrl_t;

    //                                    zx ix lx zt it lt zr ir lr zc lc ec s
    localparam ctrl_t CTRL_NONE = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam ctrl_t CTRL_INIT = 13'b0_0_1_0_1_0_1_0_0_1_0_0_0;
    localparam ctrl_t CTRL_MULX = 13'b0_0_0_0_0_1_0_0_0_0_0_0_0;
    localparam ctrl_t CTRL_MULC = 13'b0_0_0_0_0_1_0_0_0_0_0_0_1;
    localparam ctrl_t CTRL_ACC  = 13'b0_0_0_0_0_0_0_0_1_0_0_1_0;

endpackage

// File: rtl/series_ctrl_outdec.sv
// State-to-control decoder for series_controller.
// Ports:
//   state  - current FSM state
//   ctrl   - register-control vector for that state
//   ready  - high in IDLE
//   done   - high in DONE
import series_ctrl_pkg::*;

module series_ctrl_outdec (
    input  state_t state,
    output ctrl_t  ctrl,
    output logic   ready,
    output logic   done
);

    // Pure decode of the state register; no other inputs reach the outputs.
    always_comb begin
        ctrl  = CTRL_NONE;
        ready = 1'b0;
        done  = 1'b0;
        case (state)
            ST_IDLE: ready = 1'b1;
            ST_INIT: ctrl  = CTRL_INIT;
            ST_MULX: ctrl  = CTRL_MULX;
            ST_MULC: ctrl  = CTRL_MULC;
            ST_ACC:  ctrl  = CTRL_ACC;
            ST_DONE: done  = 1'b1;
            default: ctrl  = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/series_controller.sv
// Series-evaluation controller: sequences x load, temp*x, temp*coef and
// accumulate steps until the coefficient counter reports its last iteration.
// All outputs are registered copies of the decoded state, so they follow the
// state register by one clock.
// Ports:
//   clk, rst (sync, active low), start (level request), co (last-iteration flag)
//   abort (only when SERIES_CTRL_ABORT_EN is defined)
//   ready, done, zx/initx/ldx, zt/initt/ldt, zr/initr/ldr, zc/ldc/enc, s, iter
// Optional feature macro: SERIES_CTRL_ABORT_EN adds the abort input.
import series_ctrl_pkg::*;

module series_controller #(
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               co,
`ifdef SERIES_CTRL_ABORT_EN
    input  logic               abort,
`endif
    output logic               ready,
    output logic               done,
    output logic               zx,
    output logic               initx,
    output logic               ldx,
    output logic               zt,
    output logic               initt,
    output logic               ldt,
    output logic               zr,
    output logic               initr,
    output logic               ldr,
    output logic               zc,
    output logic               ldc,
    output logic               enc,
    output logic               s,
    output logic [COUNT_W-1:0] iter
);

    state_t               state;
    ctrl_t                dec_ctrl;
    logic                 dec_ready;
    logic                 dec_done;
    ctrl_t                ctrl_r;
    logic                 ready_r;
    logic                 done_r;
    logic [COUNT_W-1:0]   iter_r;

    series_ctrl_outdec u_outdec (
        .state (state),
        .ctrl  (dec_ctrl),
        .ready (dec_ready),
        .done  (dec_done)
    );

    // FSM: state transitions, iteration counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            iter_r  <= {COUNT_W{1'b0}};
            ctrl_r  <= CTRL_NONE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end
`ifdef SERIES_CTRL_ABORT_EN
        // Abort drops every control for one cycle and keeps iter as it was.
        else if (abort && (state != ST_IDLE)) begin
            state   <= ST_IDLE;
            ctrl_r  <= CTRL_NONE;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
        end
`endif
        else begin
            ctrl_r  <= dec_ctrl;
            ready_r <= dec_ready;
            done_r  <= dec_done;
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_INIT;
                    else       state <= ST_IDLE;
                end
                ST_INIT: begin
                    iter_r <= {COUNT_W{1'b0}};
                    state  <= ST_MULX;
                end
                ST_MULX: state <= ST_MULC;
                ST_MULC: state <= ST_ACC;
                ST_ACC: begin
                    iter_r <= iter_r + COUNT_W'(1);
                    if (co) state <= ST_DONE;
                    else    state <= ST_MULX;
                end
                // Stay until start drops so one start level gives one run.
                ST_DONE: begin
                    if (start) state <= ST_DONE;
                    else       state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready = ready_r;
    assign done  = done_r;
    assign zx    = ctrl_r.zx;
    assign initx = ctrl_r.initx;
    assign ldx   = ctrl_r.ldx;
    assign zt    = ctrl_r.zt;
    assign initt = ctrl_r.initt;
    assign ldt   = ctrl_r.ldt;
    assign zr    = ctrl_r.zr;
    assign initr = ctrl_r.initr;
    assign ldr   = ctrl_r.ldr;
    assign zc    = ctrl_r.zc;
    assign ldc   = ctrl_r.ldc;
    assign enc   = ctrl_r.enc;
    assign s     = ctrl_r.s;
    assign iter  = iter_r;

endmodule

// File: tb/tb_series_controller.sv
// Directed self-checking bench for series_controller.
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
module tb_series_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       co;
`ifdef SERIES_CTRL_ABORT_EN
    logic       abort;
`endif
    logic       ready, done;
    logic       zx, initx, ldx, zt, initt, ldt, zr, initr, ldr, zc, ldc, enc, s;
    logic [3:0] iter;

    int checks = 0;
    int errors = 0;

    series_controller #(.COUNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .co    (co),
`ifdef SERIES_CTRL_ABORT_EN
        .abort (abort),
`endif
        .ready (ready),
        .done  (done),
        .zx    (zx),
        .initx (initx),
        .ldx   (ldx),
        .zt    (zt),
        .initt (initt),
        .ldt   (ldt),
        .zr    (zr),
        .initr (initr),
        .ldr   (ldr),
        .zc    (zc),
        .ldc   (ldc),
        .enc   (enc),
        .s     (s),
        .iter  (iter)
    );

    always #5 clk = ~clk;

    // {ready,done,ldx,initt,zr,zc,ldt,s,ldr,enc} and the always-zero group
    wire [9:0]  obs   = {ready, done, ldx, initt, zr, zc, ldt, s, ldr, enc};
    wire [4:0]  zeros = {zx, initx, zt, initr, ldc};
    wire [14:0] all_o = {ready, done, zx, initx, ldx, zt, initt, ldt, zr, initr, ldr, zc, ldc, enc, s};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected observable outputs when the state register held phase m during the previous cycle.
    // m<0: IDLE, m==0: INIT, 1..3n: MULX/MULC/ACC cycles, beyond: DONE.
    function automatic logic [9:0] exp_out(input int m, input int n);
        logic [9:0] e;
        if (m < 0)           e = 10'b10_0000_0000;
        else if (m == 0)     e = 10'b00_1111_0000;
        else if (m <= 3 * n) begin
            case ((m - 1) % 3)
                0:       e = 10'b00_0000_1000;
                1:       e = 10'b00_0000_1100;
                default: e = 10'b00_0000_0011;
            endcase
        end
        else                 e = 10'b01_0000_0000;
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; co = 1'b1;
        step();
        step();
        checks++;
        if (all_o !== 15'b100_0000_0000_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", all_o, 15'b100_0000_0000_0000);
        end
        checks++;
        if (iter !== 4'd0) begin
            errors++;
            $display("FAIL reset_iter: got %0d expected 0", iter);
        end
        start = 1'b0; co = 1'b0; rst = 1'b1;
        step();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_stays: ready got %b expected 1", ready);
        end
    endtask

    // One full run with co high in the n-th ACC; optionally spurious co in MULX/MULC
    // and start held high for 'hold' extra cycles in DONE.
    task automatic run_series(input string name, input int n, input bit spur, input int hold);
        int ldr_cnt;
        int m;
        ldr_cnt = 0;
        start = 1'b1; co = 1'b0;
        step();                                  // edge 0 samples start
        checks++;
        if (obs !== exp_out(-1, n)) begin
            errors++;
            $display("FAIL %s edge 0: got %b expected %b", name, obs, exp_out(-1, n));
        end
        for (int k = 1; k <= 3 * n + 2 + hold; k++) begin
            m  = k - 1;
            co = (m == 3 * n) || (spur && m >= 1 && m < 3 * n && ((m - 1) % 3) != 2);
            step();
            checks++;
            if (obs !== exp_out(m, n) || zeros !== 5'b0) begin
                errors++;
                $display("FAIL %s edge %0d: got %b/%b expected %b/00000", name, k, obs, zeros, exp_out(m, n));
            end
            if (ldr === 1'b1) ldr_cnt++;
        end
        co = 1'b0; start = 1'b0;
        step();                                  // state returns to IDLE here
        step();                                  // outputs show IDLE
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle: ready/done got %b%b expected 10", name, ready, done);
        end
        checks++;
        if (ldr_cnt != n) begin
            errors++;
            $display("FAIL %s ldr_count: got %0d expected %0d", name, ldr_cnt, n);
        end
        checks++;
        if (iter !== 4'(n % 16)) begin
            errors++;
            $display("FAIL %s iter: got %0d expected %0d", name, iter, n % 16);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; co = 1'b0;
        step();                                  // edge 0: INIT
        for (int k = 1; k <= 5; k++) step();     // edge 5: second MULC
        checks++;
        if (iter !== 4'd1) begin
            errors++;
            $display("FAIL midrun_pre_iter: got %0d expected 1", iter);
        end
        rst = 1'b0;
        step();
        checks++;
        if (all_o !== 15'b100_0000_0000_0000 || iter !== 4'd0) begin
            errors++;
            $display("FAIL midrun_reset: got %b iter %0d expected %b iter 0", all_o, iter, 15'b100_0000_0000_0000);
        end
        rst = 1'b1; start = 1'b0;
        step();
        step();
        checks++;
        if (all_o !== 15'b100_0000_0000_0000) begin
            errors++;
            $display("FAIL midrun_after: got %b expected %b", all_o, 15'b100_0000_0000_0000);
        end
    endtask

`ifdef SERIES_CTRL_ABORT_EN
    task automatic test_abort();
        int done_seen;
        done_seen = 0;
        start = 1'b1; co = 1'b0; abort = 1'b0;
        step();                                  // edge 0: INIT
        for (int k = 1; k <= 18; k++) step();    // state is the 6th ACC, iter = 5
        abort = 1'b1; start = 1'b0;
        step();
        abort = 1'b0;
        checks++;
        if (all_o !== 15'b0 || iter !== 4'd5) begin
            errors++;
            $display("FAIL abort_cycle: got %b iter %0d expected all 0 iter 5", all_o, iter);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            if (done === 1'b1) done_seen++;
        end
        checks++;
        if (ready !== 1'b1 || done_seen != 0 || iter !== 4'd5) begin
            errors++;
            $display("FAIL abort_idle: ready %b done_seen %0d iter %0d expected 1 0 5", ready, done_seen, iter);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; co = 1'b0;
`ifdef SERIES_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        run_series("short_run", 1, 1'b0, 0);
        run_series("back_to_back", 1, 1'b0, 0);
        run_series("full_run", 16, 1'b0, 0);
        run_series("spurious_co", 3, 1'b1, 0);
        run_series("held_start", 2, 1'b0, 10);
        test_reset_mid_run();
`ifdef SERIES_CTRL_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/series_controller.md
SERIES_CONTROLLER -- requirements
Module: series_controller

Interface
REQ-001 Parameter: COUNT_W, 4, width of the iter debug output.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 start  input  1  level request to begin one series evaluation.
REQ-005 co  input  1  carry-out from the datapath coefficient counter; high on the final iteration.
REQ-006 ready  output  1  high only in IDLE.
REQ-007 done  output  1  high only in DONE; result is valid while done is high.
REQ-008 zx, initx, ldx  output  1 each  x-register clear, init and load.
REQ-009 zt, initt, ldt  output  1 each  temp-register clear, init-to-one and load.
REQ-010 zr, initr, ldr  output  1 each  result-register clear, init and load.
REQ-011 zc, ldc, enc  output  1 each  counter clear, load and enable.
REQ-012 s  output  1  mux select: 0 selects x, 1 selects the LUT coefficient.
REQ-013 iter  output  COUNT_W  number of completed accumulate steps in the current run.

Function
REQ-014 States SHALL be IDLE, INIT, MULX, MULC, ACC and DONE.
REQ-015 IDLE -> INIT when start=1; otherwise the FSM stays in IDLE.
REQ-016 INIT SHALL assert ldx, initt, zr and zc for exactly one cycle, clear iter, and go to MULX.
REQ-017 MULX SHALL assert ldt with s=0 (temp <= temp*x), then go to MULC.
REQ-018 MULC SHALL assert ldt with s=1 (temp <= temp*coef), then go to ACC.
REQ-019 ACC SHALL assert ldr and enc and increment iter (wrapping modulo 2^COUNT_W); next state is DONE if co=1, else MULX.
REQ-020 DONE SHALL hold all register controls low and stay in DONE while start=1; DONE -> IDLE when start=0 (level handshake, so one start level produces one run).
REQ-021 Any control not named for a state SHALL be 0 in that state; s SHALL be 0 outside MULC; zx, initx, zt, initr and ldc SHALL be constant 0.
REQ-022 With co first high in the Nth ACC, done SHALL rise 3N+2 clock edges after the edge that samples start=1 in IDLE (50 edges for N=16).
REQ-023 The value of co SHALL be ignored in every state except ACC.
REQ-024 All outputs SHALL be registered or decoded from the state register only, with no combinational path from start or co to any output.

Reset
REQ-025 When rst=0 on a clock edge: state <= IDLE, iter <= 0; this has priority over every transition, including mid-run.
REQ-026 During and after reset: ready=1, done=0, all register controls 0, s=0.

Configuration
REQ-027 With SERIES_CTRL_ABORT_EN defined: input abort (1 bit) SHALL be added; abort=1 in any state except IDLE forces next state IDLE, suppresses done, drives all controls 0 that cycle, and leaves iter unchanged.
REQ-028 Without SERIES_CTRL_ABORT_EN: the abort port SHALL NOT exist, and the behaviour is exactly REQ-014 to REQ-026.

Structure
REQ-029 Package series_ctrl_pkg SHALL hold the state enum and its encoding, plus a 13-bit control-vector typedef with named per-state constants.
REQ-030 A single sub-module, series_ctrl_outdec, SHALL map the state to the control vector; all other logic is in series_controller.

Verification
REQ-031 Reset mid-run: rst=0 while in MULC -> next edge gives IDLE, ready=1, iter=0, all controls 0.
REQ-032 Full run: start=1, co pulsed in the 16th ACC -> ldr/enc seen 16 times, iter=0 (wrapped, COUNT_W=4), done at edge 50.
REQ-033 Short run: co=1 in the 1st ACC -> control sequence INIT, MULX, MULC, ACC, DONE; done at edge 5; iter=1.
REQ-034 Held start: start kept at 1 through DONE for 10 cycles -> done stays 1 and no second INIT occurs; start=0 -> IDLE on the next edge.
REQ-035 Spurious co: co=1 during MULX/MULC -> no transition to DONE; the run continues normally.
REQ-036 Abort (SERIES_CTRL_ABORT_EN defined): abort=1 in ACC with iter=5 -> IDLE next edge, done never asserted, iter=5.
